// File: rtl/dd_pkg.sv
// Shared definitions for the sequential double-dabble converter.
// Holds the FSM state encoding and elaboration-time sizing helpers.
// No logic lives here; everything is constant or type-level.
package dd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Decimal digits needed to hold any width-bit unsigned value:
    // ceil(width * log10(2)), with log10(2) approximated as 0.30103.
    function automatic int min_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

    // Bits needed to represent values 0..value-1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
// Latency: purely combinational.
// Backpressure: none; pure function of the input.
module bcd_add3_digit (
    input  logic [3:0] i_dig,
    output logic [3:0] o_dig
);

    assign o_dig = (i_dig >= 4'd5) ? (i_dig + 4'd3) : i_dig;

endmodule

// File: rtl/seq_double_dabbler.sv
// Binary-to-BCD converter, shift-and-add-3, one bit per clock, optional signed input.
// Latency: FINISH pulses BIN_WIDTH+1 cycles after START acceptance; one result per BIN_WIDTH+2 cycles.
// Backpressure: START is only accepted in IDLE; requests while BUSY are dropped, not queued.
module seq_double_dabbler
    import dd_pkg::*;
#(
    parameter int BIN_WIDTH   = 16,
    parameter int DIGITS      = 5,
    parameter bit SIGNED_MODE = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [BIN_WIDTH-1:0]  i_bin,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_sign,
    output logic                  o_ovf,
    output logic                  o_busy,
    output logic                  o_finish
);

    localparam int CW = clog2(BIN_WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    // With enough digits no bit can ever leave the top digit, so the
    // overflow flop is only allowed to set when the digit count is short.
    localparam bit OVF_POSSIBLE = (DIGITS < min_digits(BIN_WIDTH));

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [BIN_WIDTH-1:0]   r_mag;
    logic [BW-1:0]          r_dig;
    logic [CW-1:0]          r_cnt;
    logic                   r_neg;
    logic                   r_ovf_acc;
    logic [BW-1:0]          r_bcd;
    logic                   r_sign;
    logic                   r_ovf;
    logic                   r_finish;

    logic                   w_accept;
    logic                   w_neg;
    logic [BIN_WIDTH-1:0]   w_mag;
    logic [BW-1:0]          w_adj;
    logic                   w_carry;
    logic [BW-1:0]          w_dig_sh;
    logic [BIN_WIDTH-1:0]   w_mag_sh;

    assign w_accept = (r_state == ST_IDLE) && i_start;

    // Negative operands are converted to magnitude up front; the most-negative
    // value negates to itself, which read as unsigned is the correct magnitude.
    assign w_neg = SIGNED_MODE && i_bin[BIN_WIDTH-1];
    assign w_mag = w_neg ? ((~i_bin) + BIN_WIDTH'(1)) : i_bin;

    // Per-digit add-3 correction applied before every shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .i_dig (r_dig[4*g +: 4]),
            .o_dig (w_adj[4*g +: 4])
        );
    end

    assign {w_carry, w_dig_sh, w_mag_sh} = {w_adj, r_mag, 1'b0};

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE waits for START, SHIFT runs BIN_WIDTH steps, DONE publishes.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (r_cnt == CW'(1)) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Scratch shift register, step counter, latched sign and sticky overflow.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mag     <= '0;
            r_dig     <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_ovf_acc <= 1'b0;
        end else if (w_accept) begin
            r_mag     <= w_mag;
            r_dig     <= '0;
            r_cnt     <= CW'(BIN_WIDTH);
            r_neg     <= w_neg;
            r_ovf_acc <= 1'b0;
        end else if (r_state == ST_SHIFT) begin
            r_mag <= w_mag_sh;
            r_dig <= w_dig_sh;
            r_cnt <= r_cnt - CW'(1);
            if (OVF_POSSIBLE && w_carry) begin
                r_ovf_acc <= 1'b1;
            end
        end
    end

    // Result registers change only when leaving DONE; FINISH is a one-cycle pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bcd    <= '0;
            r_sign   <= 1'b0;
            r_ovf    <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_finish <= (r_state == ST_DONE);
            if (r_state == ST_DONE) begin
                r_bcd  <= r_dig;
                r_sign <= r_neg;
                r_ovf  <= r_ovf_acc;
            end
        end
    end

    assign o_bcd    = r_bcd;
    assign o_sign   = r_sign;
    assign o_ovf    = r_ovf;
    assign o_finish = r_finish;
    assign o_busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_seq_double_dabbler.sv
// Self-checking bench for seq_double_dabbler: unsigned, signed and short-digit instances.
// Inputs are driven and outputs sampled on the falling clock edge.
// Every wait on the design is bounded; a timeout is reported as a failed check.
module tb_seq_double_dabbler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start;
    logic [15:0] bin [3];
    logic [19:0] bcd0;
    logic [19:0] bcd1;
    logic [15:0] bcd2;
    logic [2:0]  sign;
    logic [2:0]  ovf;
    logic [2:0]  busy;
    logic [2:0]  fin;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_double_dabbler #(.BIN_WIDTH(16), .DIGITS(5), .SIGNED_MODE(1'b0)) u_dut_u (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_bin(bin[0]),
        .o_bcd(bcd0), .o_sign(sign[0]), .o_ovf(ovf[0]), .o_busy(busy[0]), .o_finish(fin[0])
    );

    seq_double_dabbler #(.BIN_WIDTH(16), .DIGITS(5), .SIGNED_MODE(1'b1)) u_dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_bin(bin[1]),
        .o_bcd(bcd1), .o_sign(sign[1]), .o_ovf(ovf[1]), .o_busy(busy[1]), .o_finish(fin[1])
    );

    seq_double_dabbler #(.BIN_WIDTH(16), .DIGITS(4), .SIGNED_MODE(1'b0)) u_dut_4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[2]), .i_bin(bin[2]),
        .o_bcd(bcd2), .o_sign(sign[2]), .o_ovf(ovf[2]), .o_busy(busy[2]), .o_finish(fin[2])
    );

    typedef struct {
        int          d;
        logic [15:0] b;
        logic [19:0] eb;
        logic        es;
        logic        eo;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [19:0] get_bcd(input int d);
        case (d)
            0:       return bcd0;
            1:       return bcd1;
            default: return {4'h0, bcd2};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One full conversion on instance d with latency, BUSY length and pulse-width checks.
    task automatic conv(input string nm, input int d, input logic [15:0] b,
                        input logic [19:0] eb, input logic es, input logic eo);
        int lat;
        int bcnt;
        lat  = -1;
        bcnt = 0;
        @(negedge clk);
        bin[d]   = b;
        start[d] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start[d] = 1'b0;
                bin[d]   = ~b;
            end
            if (busy[d]) bcnt++;
            if (fin[d]) begin
                lat = i;
                break;
            end
        end
        chk({nm, " latency"}, 32'(lat), 32'd17);
        chk({nm, " busy_len"}, 32'(bcnt), 32'd17);
        chk({nm, " bcd"}, 32'(get_bcd(d)), 32'(eb));
        chk({nm, " sign"}, 32'(sign[d]), 32'(es));
        chk({nm, " ovf"}, 32'(ovf[d]), 32'(eo));
        @(negedge clk);
        chk({nm, " finish_width"}, 32'(fin[d]), 32'd0);
        chk({nm, " bcd_hold"}, 32'(get_bcd(d)), 32'(eb));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fcnt;
        int fidx [3];
        logic [19:0] seen;

        vecs[0]  = '{0, 16'hFFFF, 20'h65535, 1'b0, 1'b0};
        vecs[1]  = '{0, 16'h0000, 20'h00000, 1'b0, 1'b0};
        vecs[2]  = '{0, 16'd1234, 20'h01234, 1'b0, 1'b0};
        vecs[3]  = '{1, 16'h8000, 20'h32768, 1'b1, 1'b0};
        vecs[4]  = '{1, 16'hFFFF, 20'h00001, 1'b1, 1'b0};
        vecs[5]  = '{1, 16'h7FFF, 20'h32767, 1'b0, 1'b0};
        vecs[6]  = '{1, 16'h0000, 20'h00000, 1'b0, 1'b0};
        vecs[7]  = '{2, 16'd12345, 20'h02345, 1'b0, 1'b1};
        vecs[8]  = '{2, 16'd9999, 20'h09999, 1'b0, 1'b0};
        vecs[9]  = '{0, 16'd100, 20'h00100, 1'b0, 1'b0};
        vecs[10] = '{2, 16'hFFFF, 20'h05535, 1'b0, 1'b1};
        vecs[11] = '{1, 16'hFF85, 20'h00123, 1'b1, 1'b0};

        start  = 3'b000;
        bin[0] = '0;
        bin[1] = '0;
        bin[2] = '0;
        rst_n  = 1'b1;
        #2;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset bcd", 32'(bcd0), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset finish", 32'(fin), 32'd0);
        chk("reset sign_ovf", 32'({sign, ovf}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 12; v++) begin
            conv($sformatf("vec%0d", v), vecs[v].d, vecs[v].b, vecs[v].eb, vecs[v].es, vecs[v].eo);
        end

        // Extra START pulses during the run and BIN changes must not disturb it.
        @(negedge clk);
        bin[0]   = 16'd100;
        start[0] = 1'b1;
        fcnt = 0;
        seen = '0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            start[0] = (i == 3 || i == 10);
            if (i == 3 || i == 10) bin[0] = 16'd9999;
            if (fin[0]) begin
                fcnt++;
                seen = bcd0;
            end
        end
        start[0] = 1'b0;
        chk("ignore_start fin_count", 32'(fcnt), 32'd1);
        chk("ignore_start bcd", 32'(seen), 32'h00100);

        // START held high: back-to-back conversions every 18 cycles.
        @(negedge clk);
        bin[0]   = 16'd42;
        start[0] = 1'b1;
        fcnt = 0;
        for (int i = 0; i < 80 && fcnt < 3; i++) begin
            @(negedge clk);
            if (fin[0]) begin
                fidx[fcnt] = i;
                fcnt++;
            end
        end
        start[0] = 1'b0;
        chk("held fin_count", 32'(fcnt), 32'd3);
        if (fcnt == 3) begin
            chk("held period1", 32'(fidx[1] - fidx[0]), 32'd18);
            chk("held period2", 32'(fidx[2] - fidx[1]), 32'd18);
        end
        chk("held bcd", 32'(bcd0), 32'h00042);
        @(negedge clk);
        chk("held idle_after_drop", 32'(busy[0]), 32'd0);

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        bin[0]   = 16'd777;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (7) @(negedge clk);
        chk("midrst busy_before", 32'(busy[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst bcd0", 32'(bcd0), 32'd0);
        chk("midrst bcd1", 32'(bcd1), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst sign1", 32'(sign[1]), 32'd0);
        chk("midrst ovf2", 32'(ovf[2]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fcnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (fin != 3'b000) fcnt++;
        end
        chk("midrst stray_finish", 32'(fcnt), 32'd0);
        conv("post_reset", 0, 16'd555, 20'h00555, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
